coherence_controller: RTL and testbench

- Bus-side responder for the two-core MSI snooping protocol driven by the dcache snoop and control units.
- Arbitrates instruction fetches, data fills, evictions and invalidation upgrades from two cores onto a single RAM port.
- Drives the snoop channel (ccwait, ccinv, ccsnoopaddr) to the non-requesting core and forwards dirty blocks cache-to-cache.
- Blocks are 2 words, transferred one word per RAM ACCESS.

---
 rtl/coherence_controller.sv | 193 +++++++++++++++++++
 tb/tb_coherence_controller.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_controller.sv
// Two-core MSI bus controller. It puts instruction fetches, data fills,
// evictions and upgrades from both cores onto one RAM port. It also drives
// the snoop channel to the core that did not make the request, and it
// forwards dirty blocks from one cache to the other.
module coherence_controller #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [1:0]             iREN,
  input  logic [1:0][ADDR_W-1:0] iaddr,
  output logic [1:0]             iwait,
  output logic [1:0][WORD_W-1:0] iload,
  input  logic [1:0]             dREN,
  input  logic [1:0]             dWEN,
  input  logic [1:0][ADDR_W-1:0] daddr,
  input  logic [1:0][WORD_W-1:0] dstore,
  output logic [1:0]             dwait,
  output logic [1:0][WORD_W-1:0] dload,
  input  logic [1:0]             cctrans,
  input  logic [1:0]             ccwrite,
  output logic [1:0]             ccwait,
  output logic [1:0]             ccinv,
  output logic [1:0][ADDR_W-1:0] ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [ADDR_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate
);

  // The RAM completes a word only in the ACCESS state.
  // FREE, BUSY and ERROR all mean "hold and keep the strobes up".
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [3:0] {
    IDLE,
    SNOOP,
    RAM0,
    RAM1,
    C2C0,
    C2C1,
    INV,
    WB0,
    WB1,
    IFETCH
  } state_t;

  state_t state, next_state;

  // req is the core that owns the current transaction (for IFETCH it is the
  // fetching core). The snooped core is always the other one.
  logic req;
  logic snp;
  logic rr;

  // Outputs of the arbiter (valid only while the FSM is in IDLE).
  logic   grant_valid;
  logic   grant_core;
  logic   grant_data;
  state_t grant_state;
  logic   access;
  logic [1:0] evict;

  assign snp    = ~req;
  assign access = (ramstate == RAM_ACCESS);
  assign evict  = dWEN & ~cctrans;

  // Pick one request by class: coherence, then eviction, then fetch.
  // When both cores are in the same class, rr breaks the tie.
  always_comb begin
    grant_valid = 1'b0;
    grant_core  = rr;
    grant_data  = 1'b0;
    grant_state = IDLE;
    if (|cctrans) begin
      grant_valid = 1'b1;
      grant_data  = 1'b1;
      grant_state = SNOOP;
      grant_core  = (&cctrans) ? rr : cctrans[1];
    end else if (|evict) begin
      grant_valid = 1'b1;
      grant_data  = 1'b1;
      grant_state = WB0;
      grant_core  = (&evict) ? rr : evict[1];
    end else if (|iREN) begin
      grant_valid = 1'b1;
      grant_state = IFETCH;
      grant_core  = (&iREN) ? rr : iREN[1];
    end
  end

  // State register. An async reset drops the FSM straight back to IDLE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Latch the granted core. A data grant flips rr. A fetch grant hands
  // priority to the other core.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      req <= 1'b0;
      rr  <= 1'b0;
    end else if (state == IDLE && grant_valid) begin
      req <= grant_core;
      rr  <= grant_data ? ~rr : ~grant_core;
    end
  end

  // Next-state logic and the bus, snoop and wait outputs for each state.
  always_comb begin
    next_state  = state;
    dwait       = 2'b11;
    iwait       = 2'b11;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    dload       = '0;
    iload       = '0;

    // The snoop channel stays up from SNOOP through the forward of a dirty block.
    if (state == SNOOP || state == C2C0 || state == C2C1) begin
      ccwait[snp]      = 1'b1;
      ccsnoopaddr[snp] = daddr[req];
      ccinv[snp]       = ccwrite[req];
    end

    case (state)
      IDLE: begin
        if (grant_valid) next_state = grant_state;
      end
      SNOOP: begin
        if (cctrans[snp] && ccwrite[snp]) next_state = C2C0;
        else if (dREN[req])               next_state = RAM0;
        else                              next_state = INV;
      end
      RAM0, RAM1: begin
        ramREN     = 1'b1;
        ramaddr    = daddr[req];
        dload[req] = ramload;
        if (access) begin
          dwait[req] = 1'b0;
          next_state = (state == RAM0) ? RAM1 : IDLE;
        end
      end
      C2C0, C2C1: begin
        ramWEN     = 1'b1;
        ramaddr    = daddr[snp];
        ramstore   = dstore[snp];
        dload[req] = dstore[snp];
        if (access) begin
          dwait[snp] = 1'b0;
          dwait[req] = 1'b0;
          next_state = (state == C2C0) ? C2C1 : IDLE;
        end
      end
      INV: begin
        dwait[req] = 1'b0;
        next_state = IDLE;
      end
      WB0, WB1: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[req];
        ramstore = dstore[req];
        if (access) begin
          dwait[req] = 1'b0;
          next_state = (state == WB0) ? WB1 : IDLE;
        end
      end
      IFETCH: begin
        ramREN     = 1'b1;
        ramaddr    = iaddr[req];
        iload[req] = ramload;
        if (access) begin
          iwait[req] = 1'b0;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coherence_controller.sv
// Directed scoreboard bench for coherence_controller. A small RAM model
// inserts BUSY cycles and can be forced into ERROR.
module tb_coherence_controller;
  localparam int WORD_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int RAM_LAT = 2;

  logic                   CLK = 1'b0;
  logic                   nRST;
  logic [1:0]             iREN;
  logic [1:0][ADDR_W-1:0] iaddr;
  logic [1:0]             iwait;
  logic [1:0][WORD_W-1:0] iload;
  logic [1:0]             dREN;
  logic [1:0]             dWEN;
  logic [1:0][ADDR_W-1:0] daddr;
  logic [1:0][WORD_W-1:0] dstore;
  logic [1:0]             dwait;
  logic [1:0][WORD_W-1:0] dload;
  logic [1:0]             cctrans;
  logic [1:0]             ccwrite;
  logic [1:0]             ccwait;
  logic [1:0]             ccinv;
  logic [1:0][ADDR_W-1:0] ccsnoopaddr;
  logic                   ramREN;
  logic                   ramWEN;
  logic [ADDR_W-1:0]      ramaddr;
  logic [WORD_W-1:0]      ramstore;
  logic [WORD_W-1:0]      ramload;
  logic [1:0]             ramstate;

  coherence_controller #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  // RAM model: the read data is a fixed function of the address, so the
  // bench can work out every expected word on its own.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  int   ram_cnt;
  logic force_error = 1'b0;

  assign ramload = pat(ramaddr);

  // RAM status: BUSY for RAM_LAT cycles per word, then ACCESS.
  // ERROR when forced. FREE when no strobe is up.
  always_comb begin
    ramstate = 2'd0;
    if (force_error)                 ramstate = 2'd3;
    else if (!(ramREN || ramWEN))    ramstate = 2'd0;
    else if (ram_cnt >= RAM_LAT)     ramstate = 2'd2;
    else                             ramstate = 2'd1;
  end

  // Latency counter for the RAM model. It restarts after each completed
  // word, on an error, and when the strobes are idle.
  always @(posedge CLK) begin
    if (!nRST || force_error || !(ramREN || ramWEN) || ramstate == 2'd2) ram_cnt <= 0;
    else ram_cnt <= ram_cnt + 1;
  end

  // Scoreboard of expected observations, consumed in order.
  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic pushExp(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    sb_t e;
    vectors++;
    if (sbq.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard_empty: got %h with no expected entry", observed);
    end else begin
      e = sbq.pop_front();
      assert (observed === e.exp) else begin
        miscompares++;
        $error("[TB] FAIL %s: got %h expected %h", e.tag, observed, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input bit core, input logic ren, input logic wen,
                               input logic ct, input logic cw,
                               input logic [31:0] addr, input logic [31:0] store);
    dREN[core]    = ren;
    dWEN[core]    = wen;
    cctrans[core] = ct;
    ccwrite[core] = cw;
    daddr[core]   = addr;
    dstore[core]  = store;
    #1;
  endtask

  task automatic applyFetch(input bit core, input logic ren, input logic [31:0] addr);
    iREN[core]  = ren;
    iaddr[core] = addr;
    #1;
  endtask

  // Wait, with a bounded number of cycles, for one wait line to drop.
  task automatic waitLow(input bit instr, input bit core);
    int n;
    n = 0;
    while (((instr ? iwait[core] : dwait[core]) !== 1'b0) && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    assert ((instr ? iwait[core] : dwait[core]) === 1'b0) else begin
      miscompares++;
      $error("[TB] FAIL %s%0d_drop: got 1 after %0d cycles expected 0", instr ? "iwait" : "dwait", core, n);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0;
    iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
    cctrans = '0; ccwrite = '0;

    $display("[TB] reset values");
    pushExp("rst_dwait", 32'h3); pushExp("rst_iwait", 32'h3); pushExp("rst_ccwait", 32'h0);
    pushExp("rst_ccinv", 32'h0); pushExp("rst_strobes", 32'h0); pushExp("rst_ramaddr", 32'h0);
    pushExp("rst_ramstore", 32'h0); pushExp("rst_dload0", 32'h0); pushExp("rst_snoopaddr1", 32'h0);
    tick(); tick();
    checkOutput(dwait); checkOutput(iwait); checkOutput(ccwait); checkOutput(ccinv);
    checkOutput({ramREN, ramWEN}); checkOutput(ramaddr); checkOutput(ramstore);
    checkOutput(dload[0]); checkOutput(ccsnoopaddr[1]);
    nRST = 1'b1;
    tick();

    $display("[TB] core0 fill from RAM");
    applyStimulus(1'b0, 1, 0, 1, 0, 32'h100, 32'h0);
    pushExp("t1_ccwait", 32'h2); pushExp("t1_snoopaddr1", 32'h100);
    pushExp("t1_ccinv", 32'h0); pushExp("t1_snoop_strobes", 32'h0);
    tick();
    checkOutput(ccwait); checkOutput(ccsnoopaddr[1]); checkOutput(ccinv); checkOutput({ramREN, ramWEN});
    pushExp("t1_ram0_ccwait", 32'h0); pushExp("t1_ram0_strobes", 32'h2);
    pushExp("t1_w0_addr", 32'h100); pushExp("t1_w0_dload", pat(32'h100)); pushExp("t1_w0_dwait", 32'h2);
    tick();
    checkOutput(ccwait); checkOutput({ramREN, ramWEN});
    waitLow(1'b0, 1'b0);
    checkOutput(ramaddr); checkOutput(dload[0]); checkOutput(dwait);
    applyStimulus(1'b0, 1, 0, 1, 0, 32'h104, 32'h0);
    pushExp("t1_w1_addr", 32'h104); pushExp("t1_w1_dload", pat(32'h104));
    tick();
    waitLow(1'b0, 1'b0);
    checkOutput(ramaddr); checkOutput(dload[0]);
    applyStimulus(1'b0, 0, 0, 0, 0, 32'h0, 32'h0);
    pushExp("t1_idle_dwait", 32'h3); pushExp("t1_idle_strobes", 32'h0);
    tick();
    checkOutput(dwait); checkOutput({ramREN, ramWEN});

    $display("[TB] core0 fill forwarded from dirty core1");
    applyStimulus(1'b0, 1, 0, 1, 0, 32'h100, 32'h0);
    pushExp("t2_ccwait", 32'h2); pushExp("t2_ccinv", 32'h0);
    tick();
    checkOutput(ccwait); checkOutput(ccinv);
    applyStimulus(1'b1, 0, 0, 1, 1, 32'h100, 32'hDEAD);
    pushExp("t2_c2c_strobes", 32'h1); pushExp("t2_c2c_ccwait", 32'h2); pushExp("t2_c2c_ccinv", 32'h0);
    pushExp("t2_w0_dwait", 32'h0); pushExp("t2_w0_ramaddr", 32'h100);
    pushExp("t2_w0_ramstore", 32'hDEAD); pushExp("t2_w0_dload", 32'hDEAD);
    tick();
    checkOutput({ramREN, ramWEN}); checkOutput(ccwait); checkOutput(ccinv);
    waitLow(1'b0, 1'b0);
    checkOutput(dwait); checkOutput(ramaddr); checkOutput(ramstore); checkOutput(dload[0]);
    applyStimulus(1'b0, 1, 0, 1, 0, 32'h104, 32'h0);
    applyStimulus(1'b1, 0, 0, 1, 1, 32'h104, 32'hBEEF);
    pushExp("t2_w1_dwait", 32'h0); pushExp("t2_w1_ramstore", 32'hBEEF);
    pushExp("t2_w1_dload", 32'hBEEF); pushExp("t2_w1_ramaddr", 32'h104);
    tick();
    waitLow(1'b0, 1'b0);
    checkOutput(dwait); checkOutput(ramstore); checkOutput(dload[0]); checkOutput(ramaddr);
    applyStimulus(1'b0, 0, 0, 0, 0, 32'h0, 32'h0);
    applyStimulus(1'b1, 0, 0, 0, 0, 32'h0, 32'h0);
    pushExp("t2_idle_ccwait", 32'h0); pushExp("t2_idle_dwait", 32'h3);
    tick();
    checkOutput(ccwait); checkOutput(dwait);

    $display("[TB] core1 upgrade");
    applyStimulus(1'b1, 0, 0, 1, 1, 32'h200, 32'h0);
    pushExp("t3_ccwait", 32'h1); pushExp("t3_ccinv", 32'h1); pushExp("t3_snoopaddr0", 32'h200);
    tick();
    checkOutput(ccwait); checkOutput(ccinv); checkOutput(ccsnoopaddr[0]);
    pushExp("t3_inv_dwait", 32'h1); pushExp("t3_inv_strobes", 32'h0); pushExp("t3_inv_ccwait", 32'h0);
    tick();
    checkOutput(dwait); checkOutput({ramREN, ramWEN}); checkOutput(ccwait);
    applyStimulus(1'b1, 0, 0, 0, 0, 32'h0, 32'h0);
    pushExp("t3_idle_dwait", 32'h3);
    tick();
    checkOutput(dwait);

    $display("[TB] core0 eviction");
    applyStimulus(1'b0, 0, 1, 0, 0, 32'h300, 32'h1111_1111);
    pushExp("t4_wb_flags", 32'h1); pushExp("t4_w0_addr", 32'h300);
    pushExp("t4_w0_store", 32'h1111_1111); pushExp("t4_w0_dwait", 32'h2);
    tick();
    checkOutput({ccwait, ramREN, ramWEN});
    waitLow(1'b0, 1'b0);
    checkOutput(ramaddr); checkOutput(ramstore); checkOutput(dwait);
    applyStimulus(1'b0, 0, 1, 0, 0, 32'h304, 32'h2222_2222);
    pushExp("t4_w1_addr", 32'h304); pushExp("t4_w1_store", 32'h2222_2222); pushExp("t4_w1_flags", 32'h1);
    tick();
    waitLow(1'b0, 1'b0);
    checkOutput(ramaddr); checkOutput(ramstore); checkOutput({ccwait, ramREN, ramWEN});
    applyStimulus(1'b0, 0, 0, 0, 0, 32'h0, 32'h0);
    pushExp("t4_idle_dwait", 32'h3);
    tick();
    checkOutput(dwait);

    $display("[TB] simultaneous fills, round robin");
    applyStimulus(1'b0, 1, 0, 1, 0, 32'h400, 32'h0);
    applyStimulus(1'b1, 1, 0, 1, 0, 32'h500, 32'h0);
    pushExp("t5_a_ccwait", 32'h2); pushExp("t5_a_snoopaddr1", 32'h400);
    tick();
    checkOutput(ccwait); checkOutput(ccsnoopaddr[1]);
    pushExp("t5_a_w0_dwait", 32'h2); pushExp("t5_a_w0_addr", 32'h400); pushExp("t5_a_w0_dload", pat(32'h400));
    tick();
    waitLow(1'b0, 1'b0);
    checkOutput(dwait); checkOutput(ramaddr); checkOutput(dload[0]);
    applyStimulus(1'b0, 1, 0, 1, 0, 32'h404, 32'h0);
    pushExp("t5_a_w1_dload", pat(32'h404));
    tick();
    waitLow(1'b0, 1'b0);
    checkOutput(dload[0]);
    applyStimulus(1'b0, 0, 0, 0, 0, 32'h0, 32'h0);
    pushExp("t5_mid_dwait", 32'h3);
    tick();
    checkOutput(dwait);
    pushExp("t5_b_ccwait", 32'h1); pushExp("t5_b_snoopaddr0", 32'h500);
    tick();
    checkOutput(ccwait); checkOutput(ccsnoopaddr[0]);
    pushExp("t5_b_w0_dwait", 32'h1); pushExp("t5_b_w0_addr", 32'h500); pushExp("t5_b_w0_dload", pat(32'h500));
    tick();
    waitLow(1'b0, 1'b1);
    checkOutput(dwait); checkOutput(ramaddr); checkOutput(dload[1]);
    applyStimulus(1'b1, 1, 0, 1, 0, 32'h504, 32'h0);
    pushExp("t5_b_w1_dload", pat(32'h504));
    tick();
    waitLow(1'b0, 1'b1);
    checkOutput(dload[1]);
    applyStimulus(1'b1, 0, 0, 0, 0, 32'h0, 32'h0);
    pushExp("t5_idle_dwait", 32'h3);
    tick();
    checkOutput(dwait);

    $display("[TB] data before fetch, RAM error hold");
    applyFetch(1'b0, 1, 32'h800);
    applyFetch(1'b1, 1, 32'h900);
    applyStimulus(1'b0, 1, 0, 1, 0, 32'h600, 32'h0);
    pushExp("t6_snoop_iwait", 32'h3); pushExp("t6_snoop_ccwait", 32'h2);
    tick();
    checkOutput(iwait); checkOutput(ccwait);
    tick();
    force_error = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pushExp($sformatf("t6_err%0d_waits", i), 32'hF);
      tick();
      checkOutput({iwait, dwait});
    end
    force_error = 1'b0;
    pushExp("t6_w0_dload", pat(32'h600)); pushExp("t6_w0_iwait", 32'h3);
    waitLow(1'b0, 1'b0);
    checkOutput(dload[0]); checkOutput(iwait);
    applyStimulus(1'b0, 1, 0, 1, 0, 32'h604, 32'h0);
    pushExp("t6_w1_dload", pat(32'h604));
    tick();
    waitLow(1'b0, 1'b0);
    checkOutput(dload[0]);
    applyStimulus(1'b0, 0, 0, 0, 0, 32'h0, 32'h0);
    pushExp("t6_idle_iwait", 32'h3);
    tick();
    checkOutput(iwait);
    pushExp("t6_f1_strobes", 32'h2); pushExp("t6_f1_addr", 32'h900);
    pushExp("t6_f1_iload", pat(32'h900)); pushExp("t6_f1_iwait", 32'h1);
    tick();
    checkOutput({ramREN, ramWEN}); checkOutput(ramaddr);
    waitLow(1'b1, 1'b1);
    checkOutput(iload[1]); checkOutput(iwait);
    applyFetch(1'b1, 0, 32'h0);
    pushExp("t6_idle2_iwait", 32'h3);
    tick();
    checkOutput(iwait);
    pushExp("t6_f0_addr", 32'h800); pushExp("t6_f0_iload", pat(32'h800)); pushExp("t6_f0_iwait", 32'h2);
    tick();
    checkOutput(ramaddr);
    waitLow(1'b1, 1'b0);
    checkOutput(iload[0]); checkOutput(iwait);
    applyFetch(1'b0, 0, 32'h0);
    tick();

    $display("[TB] reset during second word");
    applyStimulus(1'b1, 1, 0, 1, 0, 32'hA00, 32'h0);
    tick();
    tick();
    waitLow(1'b0, 1'b1);
    applyStimulus(1'b1, 1, 0, 1, 0, 32'hA04, 32'h0);
    pushExp("t7_ram1_addr", 32'hA04); pushExp("t7_ram1_strobes", 32'h2);
    tick();
    checkOutput(ramaddr); checkOutput({ramREN, ramWEN});
    #2;
    nRST = 1'b0;
    #1;
    pushExp("t7_rst_strobes", 32'h0); pushExp("t7_rst_dwait", 32'h3); pushExp("t7_rst_ccwait", 32'h0);
    pushExp("t7_rst_ramaddr", 32'h0); pushExp("t7_rst_dload1", 32'h0);
    checkOutput({ramREN, ramWEN}); checkOutput(dwait); checkOutput(ccwait);
    checkOutput(ramaddr); checkOutput(dload[1]);
    applyStimulus(1'b1, 0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    nRST = 1'b1;
    applyFetch(1'b0, 1, 32'h800);
    applyFetch(1'b1, 1, 32'h900);
    pushExp("t7_rr_fetch_addr", 32'h800);
    tick();
    checkOutput(ramaddr);
    waitLow(1'b1, 1'b0);
    applyFetch(1'b0, 0, 32'h0);
    applyFetch(1'b1, 0, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
